// File: rtl/fetch_inst_queue.sv
// fetch_inst_queue: small first-word-fall-through FIFO that buffers fetched
// (pc, inst) pairs between the fetch unit and the IF/ID register. It lets
// fetch run ahead while decode is stalled, and it empties completely on a
// redirect flush.
//
// Handshakes:
//   Fetch side: this is valid/ready. A transfer happens on a rising edge
//   where fetch_valid && fetch_ready && !flush. fetch_ready depends only on
//   the registered count and on reset. It never looks at fetch_valid,
//   id_stall or flush.
//   ID side: the head entry is presented while id_valid=1. It is consumed on
//   a rising edge where id_valid && !id_stall && !flush. While id_stall is
//   high, the head entry stays in place.
module fetch_inst_queue #(
    parameter int DEPTH  = 4,
    parameter int PC_W   = 64,
    parameter int INST_W = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       fetch_valid,
    input  logic [PC_W-1:0]            fetch_pc,
    input  logic [INST_W-1:0]          fetch_inst,
    output logic                       fetch_ready,
    input  logic                       id_stall,
    input  logic                       flush,
    output logic                       id_valid,
    output logic                       id_bubble,
    output logic [PC_W-1:0]            id_pc,
    output logic [INST_W-1:0]          id_inst,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PC_W-1:0]   pc_mem   [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic              push;
    logic              pop;

    // Ready comes from count alone, so there is no pop-through when full.
    // Reset also forces ready low.
    assign fetch_ready = reset && (count < FULL_CNT);
    assign id_valid    = (count != '0);
    assign id_bubble   = ~id_valid;
    assign id_pc       = pc_mem[head];
    assign id_inst     = inst_mem[head];

    assign push = fetch_valid && fetch_ready && !flush;
    assign pop  = id_valid && !id_stall && !flush;

    // Storage has no reset. Only a push writes the tail slot.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[tail]   <= fetch_pc;
            inst_mem[tail] <= fetch_inst;
        end
    end

    // Pointers and count. Flush has priority over push and pop.
    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Occupancy invariants: count stays in range, and the pointer
    // distance agrees with count.
    a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        count <= FULL_CNT);
    a_no_underflow: assert property (@(posedge clk) disable iff (!reset)
        (count == '0) |-> !pop);
    a_ptr_count: assert property (@(posedge clk) disable iff (!reset)
        PTR_W'(tail - head) == count[PTR_W-1:0]);

endmodule
